// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared constants and types for the instruction-memory
//               responder (NOP encoding, fetch FSM state enum).
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    // addi x0, x0, 0 -- canonical RISC-V no-op
    localparam logic [31:0] NOP = 32'h0000_0013;

    // Latency counter width; covers LATENCY values 1..15
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } imem_state_t;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/instr_mem_responder_imem_array.sv
`default_nettype none
// ============================================================================
// Module      : imem_array
// Description : Instruction storage with per-word "loaded" flags. One
//               synchronous write port, one combinational read port, so a
//               read in the same cycle as a write to the same word returns
//               the old contents. Words never written since reset read NOP.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_array
    import riscv_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0]    mem_q [DEPTH];
    logic [DEPTH-1:0] loaded_q;

    // Storage contents: not reset, written on a qualified load strobe
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Loaded flags: cleared on reset so stale contents read back as NOP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loaded_q <= '0;
        end else if (we_i) begin
            loaded_q[waddr_i] <= 1'b1;
        end
    end

    // Combinational read of the pre-write contents
    always_comb begin
        rdata_o = loaded_q[raddr_i] ? mem_q[raddr_i] : NOP;
    end

endmodule : imem_array
`default_nettype wire

// File: rtl/instr_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem_responder
// Description : Instruction-fetch memory responder. Accepts one fetch at a
//               time, answers after a fixed LATENCY with the instruction
//               word (or NOP + error for misaligned / out-of-range PCs),
//               holds the response under backpressure and drops it on
//               flush. Program image is loaded through a side write port.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_mem_responder
    import riscv_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_pc,
    input  logic        flush,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_instr,
    output logic [31:0] rsp_pc,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH);
    // Counter preload: WAIT lasts LATENCY cycles, so RESP is entered on the
    // LATENCY-th edge after accept.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    imem_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [31:0]      instr_q, instr_d;
    logic [31:0]      pc_q,    pc_d;
    logic             err_q,   err_d;

    logic             w_load_ok;
    logic             w_req_err;
    logic [31:0]      w_rdata;

    // Loads outside the array or not word-aligned are silently dropped
    always_comb begin
        w_load_ok = load_en && (load_addr[1:0] == 2'b00) &&
                    (32'(load_addr[31:2]) < 32'(DEPTH));
        w_req_err = (req_pc[1:0] != 2'b00) ||
                    (32'(req_pc[31:2]) >= 32'(DEPTH));
    end

    imem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_imem_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (w_load_ok),
        .waddr_i (load_addr[AW+1:2]),
        .wdata_i (load_data),
        .raddr_i (req_pc[AW+1:2]),
        .rdata_o (w_rdata)
    );

    // State and response registers; reset abandons any in-flight fetch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            instr_q <= NOP;
            pc_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic; flush always wins and discards the pending fetch
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        instr_d   = instr_q;
        pc_d      = pc_q;
        err_d     = err_q;
        req_ready = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = !flush;
                if (req_valid && !flush) begin
                    state_d = WAIT;
                    cnt_d   = CNT_LOAD;
                    instr_d = w_req_err ? NOP : w_rdata;
                    pc_d    = req_pc;
                    err_d   = w_req_err;
                end
            end
            WAIT: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (flush || rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Response outputs come straight from registers so they stay stable
    always_comb begin
        rsp_valid = (state_q == RESP);
        rsp_instr = instr_q;
        rsp_pc    = pc_q;
        rsp_err   = err_q;
    end

endmodule : instr_mem_responder
`default_nettype wire
